// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and baud-tick arithmetic
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic int unsigned calc_n_ticks(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned calc_half_ticks(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
        return calc_n_ticks(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the
// value both flops take during reset (1 for an idle-high serial line).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, LSB first) with mid-bit sampling, false-start rejection,
// stop-bit check and a one-entry AXI-stream holding register.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even).
module uart_rx_axis #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_data,
    output logic [7:0] axis_tdata,
    output logic       axis_tvalid,
    input  logic       axis_tready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    import uart_pkg::*;

    localparam int unsigned N_TICKS = calc_n_ticks(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF    = calc_half_ticks(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW      = $clog2(N_TICKS + 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(N_TICKS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    uart_state_t   state;
    logic          rx_s;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_data),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign parity_err = 1'b0 & PARITY_ODD;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            busy        <= 1'b0;
            axis_tdata  <= '0;
            axis_tvalid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
            par_bad     <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A completed transfer frees the holding register; a delivery
            // later in this cycle may reload it.
            if (axis_tvalid && axis_tready)
                axis_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_BIT) begin
                        cnt     <= '0;
                        par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_BIT) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
`endif
                        end else if (!axis_tvalid || axis_tready) begin
                            axis_tdata  <= shreg;
                            axis_tvalid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: serial frames are driven on rx_data,
// expected bytes go into a scoreboard queue and are checked on each transfer.
`timescale 1ns/1ps
module tb_uart_rx_axis;

    localparam int BIT = 217;
`ifdef UART_RX_PARITY_EN
    localparam bit USE_PAR = 1'b1;
`else
    localparam bit USE_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data = 1'b1;
    logic [7:0] axis_tdata;
    logic       axis_tvalid;
    logic       axis_tready = 1'b1;
    logic       busy, frame_err, overrun, parity_err;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vcyc = 0;
    logic [7:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_tdata = '0;
    logic       prev_fe = 1'b0, prev_ov = 1'b0;

    uart_rx_axis #(.CLK_FREQ(25_000_000), .BAUD_RATE(115200), .PARITY_ODD(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .axis_tdata  (axis_tdata),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #20 clk = ~clk;

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: event counters and scoreboard pop on each AXIS transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (parity_err) pe_cnt++;
            if (axis_tvalid) vcyc++;
            if (frame_err && prev_fe) begin
                checks++;
                failures++;
                $display("FAIL frame_err_width: frame_err high 2 cycles, required 1");
            end
            if (overrun && prev_ov) begin
                checks++;
                failures++;
                $display("FAIL overrun_width: overrun high 2 cycles, required 1");
            end
            if (stall_prev) begin
                checks++;
                if (axis_tvalid !== 1'b1 || axis_tdata !== prev_tdata) begin
                    failures++;
                    $display("FAIL axis_hold: tvalid=%b tdata=%02h, required tvalid=1 tdata=%02h",
                             axis_tvalid, axis_tdata, prev_tdata);
                end
            end
            if (axis_tvalid && axis_tready) begin
                checks++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got %02h, required no transfer", axis_tdata);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (axis_tdata !== e) begin
                        failures++;
                        $display("FAIL tdata: got %02h, required %02h", axis_tdata, e);
                    end
                end
            end
            stall_prev = axis_tvalid && !axis_tready;
            prev_tdata = axis_tdata;
            prev_fe    = frame_err;
            prev_ov    = overrun;
        end else begin
            stall_prev = 1'b0;
            prev_fe    = 1'b0;
            prev_ov    = 1'b0;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                              input int extra_hold, input int abort_bit);
        rx_data = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            if (abort_bit == i) begin
                repeat (BIT / 2) @(negedge clk);
                return;
            end
            repeat (BIT) @(negedge clk);
        end
        if (USE_PAR) begin
            rx_data = (^b) ^ 1'b0 ^ par_flip;
            repeat (BIT) @(negedge clk);
        end
        rx_data = stop_bit;
        repeat (BIT + extra_hold) @(negedge clk);
        rx_data = 1'b1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (acc_cnt >= target) break;
            @(negedge clk);
        end
        checks++;
        if (acc_cnt != target) begin
            failures++;
            $display("FAIL %s: transfers=%0d, required %0d", name, acc_cnt, target);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({axis_tvalid, axis_tdata, busy, frame_err, overrun, parity_err} !== 13'd0) begin
            failures++;
            $display("FAIL %s: tvalid=%b tdata=%02h busy=%b fe=%b ov=%b pe=%b, required all 0",
                     name, axis_tvalid, axis_tdata, busy, frame_err, overrun, parity_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_data = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b tvalid=%b, required 0 0", busy, axis_tvalid);
        end
    endtask

    task automatic test_basic;
        int base, fe0, ov0;
        base = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        vcyc = 0;
        axis_tready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 0, -1);
        wait_acc(base + 1, 50, "basic_a5_transfer");
        repeat (5) @(negedge clk);
        checks++;
        if (vcyc != 1) begin
            failures++;
            $display("FAIL basic_tvalid_cycles: got %0d, required 1", vcyc);
        end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            failures++;
            $display("FAIL basic_flags: fe=%0d ov=%0d, required %0d %0d", fe_cnt, ov_cnt, fe0, ov0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_false_start;
        int base, fe0, ov0;
        base = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        rx_data = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy: busy=%b, required 1", busy);
        end
        repeat (10) @(negedge clk);
        rx_data = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || axis_tvalid !== 1'b0 || acc_cnt != base ||
            fe_cnt != fe0 || ov_cnt != ov0) begin
            failures++;
            $display("FAIL glitch_abort: busy=%b tvalid=%b acc=%0d fe=%0d ov=%0d, required 0 0 %0d %0d %0d",
                     busy, axis_tvalid, acc_cnt, fe_cnt, ov_cnt, base, fe0, ov0);
        end
    endtask

    task automatic test_frame_err;
        int base, fe0;
        base = acc_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 2 * BIT, -1);
        repeat (BIT) @(negedge clk);
        checks++;
        if (fe_cnt != fe0 + 1 || acc_cnt != base || axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_3c: fe=%0d acc=%0d tvalid=%b, required %0d %0d 0",
                     fe_cnt, acc_cnt, axis_tvalid, fe0 + 1, base);
        end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 0, -1);
        wait_acc(base + 1, 50, "after_frame_err_55");
        checks++;
        if (fe_cnt != fe0 + 1) begin
            failures++;
            $display("FAIL frame_err_count: got %0d, required %0d", fe_cnt, fe0 + 1);
        end
    endtask

    task automatic test_overrun;
        int base, ov0;
        base = acc_cnt; ov0 = ov_cnt;
        axis_tready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 0, -1);
        repeat (BIT) @(negedge clk);
        send_frame(8'h22, 1'b1, 1'b0, 0, -1);
        repeat (20) @(negedge clk);
        checks++;
        if (ov_cnt != ov0 + 1) begin
            failures++;
            $display("FAIL overrun_count: got %0d, required %0d", ov_cnt, ov0 + 1);
        end
        checks++;
        if (axis_tvalid !== 1'b1 || axis_tdata !== 8'h11 || acc_cnt != base) begin
            failures++;
            $display("FAIL overrun_hold: tvalid=%b tdata=%02h acc=%0d, required 1 11 %0d",
                     axis_tvalid, axis_tdata, acc_cnt, base);
        end
        axis_tready = 1'b1;
        wait_acc(base + 1, 10, "overrun_drain_11");
        @(negedge clk);
        checks++;
        if (axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_tvalid_drop: tvalid=%b, required 0", axis_tvalid);
        end
    endtask

    task automatic test_reset_midframe;
        int base, fe0, ov0;
        send_frame(8'h7E, 1'b1, 1'b0, 0, 4);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        rx_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        base = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, 0, -1);
        wait_acc(base + 1, 50, "after_reset_7e");
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            failures++;
            $display("FAIL after_reset_flags: fe=%0d ov=%0d, required %0d %0d", fe_cnt, ov_cnt, fe0, ov0);
        end
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        int base, pe0;
        base = acc_cnt; pe0 = pe_cnt;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0, 0, -1);
        wait_acc(base + 1, 50, "parity_good_01");
        send_frame(8'h01, 1'b1, 1'b1, 0, -1);
        repeat (20) @(negedge clk);
        checks++;
        if (pe_cnt != pe0 + 1 || acc_cnt != base + 1 || axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL parity_bad_01: pe=%0d acc=%0d tvalid=%b, required %0d %0d 0",
                     pe_cnt, acc_cnt, axis_tvalid, pe0 + 1, base + 1);
        end
`else
        checks++;
        if (pe_cnt != 0 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_tied: pulses=%0d now=%b, required 0 0", pe_cnt, parity_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_parity();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d bytes outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
